player_motion: RTL and testbench

Per-frame vertical motion controller for the player sprite. Integrates jump impulses and gravity once per video frame and produces the registered top-edge y-coordinate that the player draw stage consumes as `luc_loc_i`. Sits between the debounced button input and the player renderer. Owns the player's IDLE/ACTIVE/LANDED life cycle.

---
 rtl/player_motion.sv | 130 +++++++++++++
 tb/tb_player_motion.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/player_motion.sv
// Per-frame vertical motion controller for the player sprite: integrates jump
// impulses and gravity on each unpaused frame tick and owns IDLE/ACTIVE/LANDED.
//
// state  | meaning
// IDLE   | parked at the spawn point, waiting for the first jump
// ACTIVE | airborne, integrating velocity and position each frame
// LANDED | resting on the floor until a jump press restarts the round
module player_motion #(
    parameter int ScreenHeight = 480,
    parameter int PlayerHeight = 60,
    parameter int StartY       = 210,
    parameter int Gravity      = 1,
    parameter int JumpVel      = 8,
    parameter int MaxFall      = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              frame_tick_i,
    input  logic              jump_i,
    input  logic              pause_i,
    output logic [8:0]        luc_loc_o,
    output logic signed [5:0] vel_o,
    output logic              active_o,
    output logic              landed_o,
    output logic              bump_o,
    output logic              land_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        LANDED = 2'd2
    } state_t;

    localparam logic [8:0]         START_Y   = 9'(StartY);
    localparam logic signed [10:0] FLOOR_Y   = 11'(ScreenHeight - PlayerHeight);
    localparam logic signed [5:0]  JUMP_NEG  = 6'(-JumpVel);
    localparam logic signed [6:0]  GRAV_S    = 7'(Gravity);
    localparam logic signed [6:0]  MAX_FALL  = 7'(MaxFall);

    state_t            state_q, state_d;
    logic [8:0]        y_q, y_d;
    logic signed [5:0] vel_q, vel_d;
    logic              jump_q, jump_pend_q, jump_pend_d;
    logic              bump_q, bump_d, land_q, land_d;

    logic              tick, jump_edge, jump_eff;
    logic signed [6:0] vel_sum;
    logic signed [5:0] v_new;
    logic signed [10:0] y_new;

    assign tick      = frame_tick_i & ~pause_i;
    assign jump_edge = jump_i & ~jump_q;
    assign jump_eff  = jump_pend_q | jump_edge;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            y_q         <= START_Y;
            vel_q       <= '0;
            jump_q      <= 1'b1;
            jump_pend_q <= 1'b0;
            bump_q      <= 1'b0;
            land_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            vel_q       <= vel_d;
            jump_q      <= jump_i;
            jump_pend_q <= jump_pend_d;
            bump_q      <= bump_d;
            land_q      <= land_d;
        end
    end

    // Candidate step: a jump overrides gravity; otherwise accelerate up to terminal speed.
    always_comb begin
        vel_sum = {vel_q[5], vel_q} + GRAV_S;
        if (jump_eff || state_q == IDLE) begin
            v_new = JUMP_NEG;
        end else if (vel_sum > MAX_FALL) begin
            v_new = MAX_FALL[5:0];
        end else begin
            v_new = vel_sum[5:0];
        end
        y_new = $signed({2'b00, y_q}) + $signed({{5{v_new[5]}}, v_new});
    end

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        vel_d       = vel_q;
        bump_d      = 1'b0;
        land_d      = 1'b0;
        jump_pend_d = jump_pend_q | jump_edge;

        if (tick) begin
            jump_pend_d = 1'b0;
            if ((state_q == IDLE && jump_eff) || state_q == ACTIVE) begin
                state_d = ACTIVE;
                if (y_new[10]) begin
                    y_d    = '0;
                    vel_d  = '0;
                    bump_d = 1'b1;
                end else if (y_new >= FLOOR_Y) begin
                    y_d     = FLOOR_Y[8:0];
                    vel_d   = '0;
                    state_d = LANDED;
                    land_d  = 1'b1;
                end else begin
                    y_d   = y_new[8:0];
                    vel_d = v_new;
                end
            end else if (state_q == LANDED && jump_eff) begin
                // Restart only; the press that leaves LANDED carries no impulse.
                state_d = IDLE;
                y_d     = START_Y;
                vel_d   = '0;
            end
        end
    end

    assign luc_loc_o = y_q;
    assign vel_o     = vel_q;
    assign active_o  = (state_q == ACTIVE);
    assign landed_o  = (state_q == LANDED);
    assign bump_o    = bump_q;
    assign land_o    = land_q;

endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: directed scenarios followed by random traffic, all
// outputs compared every cycle against a frame-level behavioural model.
module tb_player_motion;

    logic        clk = 1'b0;
    logic        rst, frame_tick, jump, pause;
    logic [8:0]  luc_loc;
    logic [5:0]  vel;
    logic        active, landed, bump, land;

    int compared   = 0;
    int mismatched = 0;

    // model: state 0=idle 1=active 2=landed
    int m_y, m_v, m_st;
    bit m_pend, m_jq, m_bump, m_land;

    always #5 clk = ~clk;

    player_motion dut (
        .clk_i(clk), .rst_i(rst), .frame_tick_i(frame_tick), .jump_i(jump),
        .pause_i(pause), .luc_loc_o(luc_loc), .vel_o(vel), .active_o(active),
        .landed_o(landed), .bump_o(bump), .land_o(land)
    );

    task automatic check(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic move(input int vn);
        int yn;
        yn = m_y + vn;
        if (yn < 0) begin
            m_y = 0; m_v = 0; m_bump = 1;
        end else if (yn >= 480 - 60) begin
            m_y = 420; m_v = 0; m_st = 2; m_land = 1;
        end else begin
            m_y = yn; m_v = vn;
        end
    endtask

    task automatic model(input bit r, input bit t, input bit j, input bit p);
        bit edge_j, eff;
        if (r) begin
            m_y = 210; m_v = 0; m_st = 0; m_pend = 0; m_jq = 1; m_bump = 0; m_land = 0;
            return;
        end
        edge_j = j && !m_jq;
        eff    = m_pend || edge_j;
        m_bump = 0;
        m_land = 0;
        if (t && !p) begin
            m_pend = 0;
            if (m_st == 0 && eff) begin
                m_st = 1;
                move(-8);
            end else if (m_st == 1) begin
                move(eff ? -8 : ((m_v + 1 > 10) ? 10 : m_v + 1));
            end else if (m_st == 2 && eff) begin
                m_st = 0; m_y = 210; m_v = 0;
            end
        end else if (edge_j) begin
            m_pend = 1;
        end
        m_jq = j;
    endtask

    task automatic cyc(input bit r, input bit t, input bit j, input bit p);
        rst = r; frame_tick = t; jump = j; pause = p;
        @(posedge clk);
        model(r, t, j, p);
        #1;
        check("y", int'(luc_loc), m_y);
        check("vel", int'($signed(vel)), m_v);
        check("active", int'(active), int'(m_st == 1));
        check("landed", int'(landed), int'(m_st == 2));
        check("bump", int'(bump), int'(m_bump));
        check("land", int'(land), int'(m_land));
    endtask

    task automatic tick_gap(input bit j);
        cyc(0, 0, j, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
    endtask

    initial begin
        int saved_y, saved_v, n;
        rst = 1; frame_tick = 0; jump = 1; pause = 0;
        m_y = 210; m_v = 0; m_st = 0; m_pend = 0; m_jq = 1; m_bump = 0; m_land = 0;

        // Button held through reset must not count as a press.
        cyc(1, 0, 1, 0);
        cyc(1, 1, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 1, 1, 0);
        check("held_thru_reset_y", int'(luc_loc), 210);
        check("held_thru_reset_active", int'(active), 0);
        for (int i = 0; i < 3; i++) tick_gap(0);
        check("idle_y", int'(luc_loc), 210);
        check("idle_vel", int'($signed(vel)), 0);

        tick_gap(1);
        check("jump_y", int'(luc_loc), 202);
        check("jump_vel", int'($signed(vel)), -8);
        check("jump_active", int'(active), 1);
        tick_gap(0);
        check("arc1_y", int'(luc_loc), 195);
        tick_gap(0);
        check("arc2_y", int'(luc_loc), 189);
        check("arc2_vel", int'($signed(vel)), -6);

        n = 0;
        while (!landed && n < 200) begin
            tick_gap(0);
            n++;
        end
        check("reached_floor", int'(landed), 1);
        check("floor_y", int'(luc_loc), 420);
        cyc(0, 0, 0, 0);
        check("land_one_cycle", int'(land), 0);

        tick_gap(1);
        check("restart_y", int'(luc_loc), 210);
        check("restart_landed", int'(landed), 0);
        check("restart_active", int'(active), 0);

        // Paused ticks hold everything, including the pending press.
        cyc(0, 1, 0, 1);
        cyc(0, 1, 1, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 1);
        cyc(0, 1, 0, 1);
        check("pause_y", int'(luc_loc), 210);
        check("pause_active", int'(active), 0);
        cyc(0, 1, 0, 0);
        check("unpause_vel", int'($signed(vel)), -8);
        check("unpause_y", int'(luc_loc), 202);

        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        check("double_press_vel", int'($signed(vel)), -8);
        check("double_press_y", int'(luc_loc), 194);

        n = 0;
        while (!bump && n < 60) begin
            tick_gap(1);
            n++;
        end
        check("ceiling_bump", int'(bump), 1);
        check("ceiling_y", int'(luc_loc), 0);
        check("ceiling_active", int'(active), 1);
        cyc(0, 0, 0, 0);
        check("bump_one_cycle", int'(bump), 0);

        tick_gap(0);
        tick_gap(0);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        check("reset_mid_y", int'(luc_loc), 210);
        check("reset_mid_active", int'(active), 0);
        cyc(0, 1, 0, 0);
        check("reset_drops_pending", int'(active), 0);

        for (int i = 0; i < 4000; i++) begin
            saved_y = ($urandom_range(0, 299) == 0) ? 1 : 0;
            saved_v = ($urandom_range(0, 9) == 0) ? 1 : 0;
            cyc(saved_y[0], $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, saved_v[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
